// File: rtl/waypoint_sequencer_pkg.sv
// Shared sign-magnitude format constants and sequencer state encoding.
package waypoint_sequencer_pkg;

  localparam int SM_W     = 17;
  localparam int MAG_W    = SM_W - 1;
  localparam int SIGN_BIT = SM_W - 1;

  localparam logic [SM_W-1:0]  SM_POS_ZERO = '0;
  localparam logic [MAG_W-1:0] SM_SAT_MAG  = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_TRACK,
    ST_CHECK,
    ST_ADVANCE
  } state_t;

endpackage

// File: rtl/waypoint_sequencer_if.sv
// Table-write, run-control, pose and error-output bundle of the waypoint sequencer.
interface waypoint_sequencer_if
  import waypoint_sequencer_pkg::*;
#(
  parameter int N_WIDTH = SM_W,
  parameter int ADDR_W  = 3
);
  logic               WAYPOINT_SEQUENCER_WR_EN;
  logic [ADDR_W-1:0]  WAYPOINT_SEQUENCER_WR_ADDR;
  logic [N_WIDTH-1:0] WAYPOINT_SEQUENCER_WR_X_InBus;
  logic [N_WIDTH-1:0] WAYPOINT_SEQUENCER_WR_Y_InBus;
  logic [N_WIDTH-1:0] WAYPOINT_SEQUENCER_WR_Z_InBus;
  logic [ADDR_W-1:0]  WAYPOINT_SEQUENCER_LAST_ADDR;
  logic               WAYPOINT_SEQUENCER_START;
  logic               WAYPOINT_SEQUENCER_ABORT;
  logic               WAYPOINT_SEQUENCER_POSE_VALID;
  logic [N_WIDTH-1:0] WAYPOINT_SEQUENCER_POSE_X_InBus;
  logic [N_WIDTH-1:0] WAYPOINT_SEQUENCER_POSE_Y_InBus;
  logic [N_WIDTH-1:0] WAYPOINT_SEQUENCER_POSE_Z_InBus;
  logic               WAYPOINT_SEQUENCER_GOAL_FLAG;
  logic [N_WIDTH-1:0] WAYPOINT_SEQUENCER_ERR_X_OutBus;
  logic [N_WIDTH-1:0] WAYPOINT_SEQUENCER_ERR_Y_OutBus;
  logic [N_WIDTH-1:0] WAYPOINT_SEQUENCER_ERR_Z_OutBus;
  logic               WAYPOINT_SEQUENCER_BUSY;
  logic               WAYPOINT_SEQUENCER_DONE;
  logic               WAYPOINT_SEQUENCER_TIMEOUT;
  logic [ADDR_W-1:0]  WAYPOINT_SEQUENCER_WP_INDEX;

  modport master (
    output WAYPOINT_SEQUENCER_WR_EN, WAYPOINT_SEQUENCER_WR_ADDR,
           WAYPOINT_SEQUENCER_WR_X_InBus, WAYPOINT_SEQUENCER_WR_Y_InBus, WAYPOINT_SEQUENCER_WR_Z_InBus,
           WAYPOINT_SEQUENCER_LAST_ADDR, WAYPOINT_SEQUENCER_START, WAYPOINT_SEQUENCER_ABORT,
           WAYPOINT_SEQUENCER_POSE_VALID, WAYPOINT_SEQUENCER_POSE_X_InBus,
           WAYPOINT_SEQUENCER_POSE_Y_InBus, WAYPOINT_SEQUENCER_POSE_Z_InBus,
           WAYPOINT_SEQUENCER_GOAL_FLAG,
    input  WAYPOINT_SEQUENCER_ERR_X_OutBus, WAYPOINT_SEQUENCER_ERR_Y_OutBus,
           WAYPOINT_SEQUENCER_ERR_Z_OutBus, WAYPOINT_SEQUENCER_BUSY, WAYPOINT_SEQUENCER_DONE,
           WAYPOINT_SEQUENCER_TIMEOUT, WAYPOINT_SEQUENCER_WP_INDEX
  );

  modport slave (
    input  WAYPOINT_SEQUENCER_WR_EN, WAYPOINT_SEQUENCER_WR_ADDR,
           WAYPOINT_SEQUENCER_WR_X_InBus, WAYPOINT_SEQUENCER_WR_Y_InBus, WAYPOINT_SEQUENCER_WR_Z_InBus,
           WAYPOINT_SEQUENCER_LAST_ADDR, WAYPOINT_SEQUENCER_START, WAYPOINT_SEQUENCER_ABORT,
           WAYPOINT_SEQUENCER_POSE_VALID, WAYPOINT_SEQUENCER_POSE_X_InBus,
           WAYPOINT_SEQUENCER_POSE_Y_InBus, WAYPOINT_SEQUENCER_POSE_Z_InBus,
           WAYPOINT_SEQUENCER_GOAL_FLAG,
    output WAYPOINT_SEQUENCER_ERR_X_OutBus, WAYPOINT_SEQUENCER_ERR_Y_OutBus,
           WAYPOINT_SEQUENCER_ERR_Z_OutBus, WAYPOINT_SEQUENCER_BUSY, WAYPOINT_SEQUENCER_DONE,
           WAYPOINT_SEQUENCER_TIMEOUT, WAYPOINT_SEQUENCER_WP_INDEX
  );

endinterface

// File: rtl/waypoint_sequencer_sm_subtract.sv
// Combinational sign-magnitude a - b with magnitude saturation; -0 inputs act as +0.
module sm_subtract
  import waypoint_sequencer_pkg::*;
(
  input  logic [SM_W-1:0] a,
  input  logic [SM_W-1:0] b,
  output logic [SM_W-1:0] diff
);

  logic [MAG_W-1:0] mag_a, mag_b, mag_r;
  logic             sign_a, sign_nb, sign_r;
  logic [MAG_W:0]   sum;

  // Computed as a + (-b); masking signs with |mag folds -0 onto +0.
  always_comb begin
    mag_a   = a[MAG_W-1:0];
    mag_b   = b[MAG_W-1:0];
    sign_a  = a[SIGN_BIT] & (|mag_a);
    sign_nb = ~b[SIGN_BIT] & (|mag_b);
    sum     = {1'b0, mag_a} + {1'b0, mag_b};
    mag_r   = '0;
    sign_r  = 1'b0;
    if (sign_a == sign_nb) begin
      mag_r  = sum[MAG_W] ? SM_SAT_MAG : sum[MAG_W-1:0];
      sign_r = sign_a;
    end else if (mag_a >= mag_b) begin
      mag_r  = mag_a - mag_b;
      sign_r = sign_a;
    end else begin
      mag_r  = mag_b - mag_a;
      sign_r = sign_nb;
    end
    diff = (mag_r == '0) ? SM_POS_ZERO : {sign_r, mag_r};
  end

endmodule

// File: rtl/waypoint_sequencer.sv
// Steps through a stored waypoint table, driving goal-minus-pose errors to the
// downstream controller and advancing once its goal flag has settled low.
module waypoint_sequencer
  import waypoint_sequencer_pkg::*;
#(
  parameter int          N_WIDTH        = SM_W,
  parameter int          ADDR_W         = 3,
  parameter int          SETTLE_COUNT   = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input logic                WAYPOINT_SEQUENCER_CLOCK_50,
  input logic                WAYPOINT_SEQUENCER_RESET_InHigh,
  waypoint_sequencer_if.slave bus
);

  logic clk, rst;
  assign clk = WAYPOINT_SEQUENCER_CLOCK_50;
  assign rst = WAYPOINT_SEQUENCER_RESET_InHigh;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  idx, last;
  logic [3:0]         settle_cnt;
  logic [31:0]        tmo_cnt;
  logic [N_WIDTH-1:0] goal_x, goal_y, goal_z;
  logic [N_WIDTH-1:0] err_x, err_y, err_z;
  logic [N_WIDTH-1:0] diff_x, diff_y, diff_z;
  logic               done, timeout;
  logic               abort, start_ok, counting, timeout_hit, settle_last, at_last;

  logic [N_WIDTH-1:0] tbl_x [0:(1<<ADDR_W)-1];
  logic [N_WIDTH-1:0] tbl_y [0:(1<<ADDR_W)-1];
  logic [N_WIDTH-1:0] tbl_z [0:(1<<ADDR_W)-1];

  assign abort       = bus.WAYPOINT_SEQUENCER_ABORT;
  assign start_ok    = bus.WAYPOINT_SEQUENCER_START && !abort;
  assign counting    = (state == ST_FETCH) || (state == ST_TRACK) || (state == ST_CHECK);
  assign timeout_hit = counting && (tmo_cnt >= TIMEOUT_CYCLES - 32'd1);
  assign settle_last = (settle_cnt == 4'(SETTLE_COUNT - 1));
  assign at_last     = (idx == last);

  // Table survives reset so a run can be repeated after an async reset.
  always_ff @(posedge clk) begin
    if (bus.WAYPOINT_SEQUENCER_WR_EN && state == ST_IDLE) begin
      tbl_x[bus.WAYPOINT_SEQUENCER_WR_ADDR] <= bus.WAYPOINT_SEQUENCER_WR_X_InBus;
      tbl_y[bus.WAYPOINT_SEQUENCER_WR_ADDR] <= bus.WAYPOINT_SEQUENCER_WR_Y_InBus;
      tbl_z[bus.WAYPOINT_SEQUENCER_WR_ADDR] <= bus.WAYPOINT_SEQUENCER_WR_Z_InBus;
    end
  end

  sm_subtract u_sub_x (.a(goal_x), .b(bus.WAYPOINT_SEQUENCER_POSE_X_InBus), .diff(diff_x));
  sm_subtract u_sub_y (.a(goal_y), .b(bus.WAYPOINT_SEQUENCER_POSE_Y_InBus), .diff(diff_y));
  sm_subtract u_sub_z (.a(goal_z), .b(bus.WAYPOINT_SEQUENCER_POSE_Z_InBus), .diff(diff_z));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (bus.WAYPOINT_SEQUENCER_START) state_n = ST_FETCH;
      ST_FETCH:   state_n = ST_TRACK;
      ST_TRACK:   if (bus.WAYPOINT_SEQUENCER_POSE_VALID) state_n = ST_CHECK;
      ST_CHECK:   state_n = (!bus.WAYPOINT_SEQUENCER_GOAL_FLAG && settle_last) ? ST_ADVANCE : ST_TRACK;
      ST_ADVANCE: state_n = at_last ? ST_IDLE : ST_FETCH;
      default:    state_n = ST_IDLE;
    endcase
    if (timeout_hit) state_n = ST_IDLE;
    if (abort)       state_n = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      last       <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      goal_x     <= '0;
      goal_y     <= '0;
      goal_z     <= '0;
      err_x      <= '0;
      err_y      <= '0;
      err_z      <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (counting) tmo_cnt <= tmo_cnt + 32'd1;
      case (state)
        ST_IDLE: if (start_ok) begin
          last       <= bus.WAYPOINT_SEQUENCER_LAST_ADDR;
          idx        <= '0;
          settle_cnt <= '0;
          tmo_cnt    <= '0;
          timeout    <= 1'b0;
        end
        ST_FETCH: begin
          goal_x <= tbl_x[idx];
          goal_y <= tbl_y[idx];
          goal_z <= tbl_z[idx];
        end
        ST_TRACK: if (bus.WAYPOINT_SEQUENCER_POSE_VALID) begin
          err_x <= diff_x;
          err_y <= diff_y;
          err_z <= diff_z;
        end
        ST_CHECK: settle_cnt <= bus.WAYPOINT_SEQUENCER_GOAL_FLAG ? '0 : settle_cnt + 4'd1;
        ST_ADVANCE: if (at_last) begin
          done <= !abort;
        end else begin
          idx        <= idx + ADDR_W'(1);
          settle_cnt <= '0;
          tmo_cnt    <= '0;
        end
        default: ;
      endcase
      if (timeout_hit && !abort) timeout <= 1'b1;
      // Any exit to IDLE commands zero velocity, overriding a same-cycle error update.
      if (state != ST_IDLE && state_n == ST_IDLE) begin
        err_x <= '0;
        err_y <= '0;
        err_z <= '0;
      end
    end
  end

  assign bus.WAYPOINT_SEQUENCER_ERR_X_OutBus = err_x;
  assign bus.WAYPOINT_SEQUENCER_ERR_Y_OutBus = err_y;
  assign bus.WAYPOINT_SEQUENCER_ERR_Z_OutBus = err_z;
  assign bus.WAYPOINT_SEQUENCER_BUSY         = (state != ST_IDLE);
  assign bus.WAYPOINT_SEQUENCER_DONE         = done;
  assign bus.WAYPOINT_SEQUENCER_TIMEOUT      = timeout;
  assign bus.WAYPOINT_SEQUENCER_WP_INDEX     = idx;

endmodule

// File: tb/tb_waypoint_sequencer.sv
// Scoreboard bench for waypoint_sequencer: stimulus queues expected responses,
// a negedge monitor pops them when the DUT presents a start, error update or stop.
module tb_waypoint_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  waypoint_sequencer_if #(.N_WIDTH(17), .ADDR_W(3)) bus ();

  waypoint_sequencer #(
    .N_WIDTH(17), .ADDR_W(3), .SETTLE_COUNT(4), .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .WAYPOINT_SEQUENCER_CLOCK_50(clk),
    .WAYPOINT_SEQUENCER_RESET_InHigh(rst),
    .bus(bus)
  );

  localparam logic [16:0] P0   = 17'h00000;
  localparam logic [16:0] NZ   = 17'h10000;
  localparam logic [16:0] P1   = 17'h00100;
  localparam logic [16:0] N1   = 17'h10100;
  localparam logic [16:0] P1_5 = 17'h00180;
  localparam logic [16:0] P2   = 17'h00200;
  localparam logic [16:0] N2   = 17'h10200;
  localparam logic [16:0] P3   = 17'h00300;
  localparam logic [16:0] P5   = 17'h00500;
  localparam logic [16:0] P10  = 17'h00A00;
  localparam logic [16:0] P90  = 17'h05A00;
  localparam logic [16:0] P100 = 17'h06400;
  localparam logic [16:0] N200 = 17'h1C800;
  localparam logic [16:0] NSAT = 17'h1FFFF;

  typedef struct {
    logic [16:0] x, y, z;
    logic [2:0]  idx;
    logic        tmo;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t q_start[$];
  exp_t q_err[$];
  exp_t q_stop[$];

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [16:0] x, y, z, input logic [2:0] idx,
                              input logic tmo, input logic done, input int cyc);
    exp_t e;
    e.x = x; e.y = y; e.z = z; e.idx = idx; e.tmo = tmo; e.done = done; e.cyc = cyc;
    return e;
  endfunction

  task automatic wr(input logic [2:0] a, input logic [16:0] x, y, z);
    bus.WAYPOINT_SEQUENCER_WR_EN     = 1'b1;
    bus.WAYPOINT_SEQUENCER_WR_ADDR   = a;
    bus.WAYPOINT_SEQUENCER_WR_X_InBus = x;
    bus.WAYPOINT_SEQUENCER_WR_Y_InBus = y;
    bus.WAYPOINT_SEQUENCER_WR_Z_InBus = z;
    tick();
    bus.WAYPOINT_SEQUENCER_WR_EN     = 1'b0;
  endtask

  // START edge, then the FETCH cycle; returns with the DUT in TRACK.
  task automatic run(input logic [2:0] last);
    q_start.push_back(mk(P0, P0, P0, 3'd0, 1'b0, 1'b0, -1));
    bus.WAYPOINT_SEQUENCER_START     = 1'b1;
    bus.WAYPOINT_SEQUENCER_LAST_ADDR = last;
    tick();
    bus.WAYPOINT_SEQUENCER_START     = 1'b0;
    tick();
  endtask

  // One pose strobe, 3 cycles; abt asserts ABORT during the CHECK cycle.
  task automatic pose(input logic [16:0] px, py, pz, input logic flag,
                      input logic [16:0] ex, ey, ez, input logic [2:0] eidx, input logic abt);
    q_err.push_back(mk(ex, ey, ez, eidx, 1'b0, 1'b0, -1));
    bus.WAYPOINT_SEQUENCER_POSE_X_InBus = px;
    bus.WAYPOINT_SEQUENCER_POSE_Y_InBus = py;
    bus.WAYPOINT_SEQUENCER_POSE_Z_InBus = pz;
    bus.WAYPOINT_SEQUENCER_POSE_VALID   = 1'b1;
    bus.WAYPOINT_SEQUENCER_GOAL_FLAG    = flag;
    tick();
    bus.WAYPOINT_SEQUENCER_POSE_VALID   = 1'b0;
    bus.WAYPOINT_SEQUENCER_ABORT        = abt;
    tick();
    bus.WAYPOINT_SEQUENCER_ABORT        = 1'b0;
    tick();
  endtask

  task automatic expect_stop(input logic [2:0] idx, input logic done, input logic tmo, input int cyc);
    q_stop.push_back(mk(P0, P0, P0, idx, tmo, done, cyc));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},    32'(bus.WAYPOINT_SEQUENCER_BUSY), 32'd0);
    chk({tag, "_done"},    32'(bus.WAYPOINT_SEQUENCER_DONE), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.WAYPOINT_SEQUENCER_TIMEOUT), 32'd0);
    chk({tag, "_wp"},      32'(bus.WAYPOINT_SEQUENCER_WP_INDEX), 32'd0);
    chk({tag, "_err_x"},   32'(bus.WAYPOINT_SEQUENCER_ERR_X_OutBus), 32'd0);
    chk({tag, "_err_y"},   32'(bus.WAYPOINT_SEQUENCER_ERR_Y_OutBus), 32'd0);
    chk({tag, "_err_z"},   32'(bus.WAYPOINT_SEQUENCER_ERR_Z_OutBus), 32'd0);
  endtask

  // Monitor
  logic pv_seen = 1'b0;
  logic busy_q  = 1'b0;
  int   cyc     = 0;

  always @(posedge clk) pv_seen <= bus.WAYPOINT_SEQUENCER_POSE_VALID;

  always @(negedge clk) begin
    exp_t e;
    logic b;
    b = bus.WAYPOINT_SEQUENCER_BUSY;
    if (rst) begin
      busy_q = b;
    end else begin
      if (b && !busy_q) begin
        cyc = 1;
        if (q_start.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_start: got busy=1 required no start at %0t", $time);
        end else begin
          e = q_start.pop_front();
          chk("start_wp", 32'(bus.WAYPOINT_SEQUENCER_WP_INDEX), 32'(e.idx));
          chk("start_timeout", 32'(bus.WAYPOINT_SEQUENCER_TIMEOUT), 32'(e.tmo));
        end
      end else if (b) begin
        cyc++;
      end
      if (pv_seen) begin
        if (q_err.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_pose: got strobe required none at %0t", $time);
        end else begin
          e = q_err.pop_front();
          chk("err_x", 32'(bus.WAYPOINT_SEQUENCER_ERR_X_OutBus), 32'(e.x));
          chk("err_y", 32'(bus.WAYPOINT_SEQUENCER_ERR_Y_OutBus), 32'(e.y));
          chk("err_z", 32'(bus.WAYPOINT_SEQUENCER_ERR_Z_OutBus), 32'(e.z));
          chk("err_wp", 32'(bus.WAYPOINT_SEQUENCER_WP_INDEX), 32'(e.idx));
        end
      end
      if (!b && busy_q) begin
        if (q_stop.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_stop: got busy=0 required busy=1 at %0t", $time);
        end else begin
          e = q_stop.pop_front();
          chk("stop_done", 32'(bus.WAYPOINT_SEQUENCER_DONE), 32'(e.done));
          chk("stop_timeout", 32'(bus.WAYPOINT_SEQUENCER_TIMEOUT), 32'(e.tmo));
          chk("stop_wp", 32'(bus.WAYPOINT_SEQUENCER_WP_INDEX), 32'(e.idx));
          chk("stop_err_x", 32'(bus.WAYPOINT_SEQUENCER_ERR_X_OutBus), 32'd0);
          chk("stop_err_y", 32'(bus.WAYPOINT_SEQUENCER_ERR_Y_OutBus), 32'd0);
          chk("stop_err_z", 32'(bus.WAYPOINT_SEQUENCER_ERR_Z_OutBus), 32'd0);
          if (e.cyc >= 0) chk("stop_busy_cycles", 32'(cyc), 32'(e.cyc));
        end
      end else if (bus.WAYPOINT_SEQUENCER_DONE) begin
        ntot++;
        $display("FAIL stray_done: got done=1 required done=0 at %0t", $time);
      end
      busy_q = b;
    end
  end

  initial begin
    #100000;
    ntot++;
    $display("FAIL watchdog: got no finish required finish by %0t", $time);
    $display("%0d/%0d checks passed", npass, ntot);
    $fatal(1);
  end

  initial begin
    logic fl [7];
    fl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    bus.WAYPOINT_SEQUENCER_WR_EN        = 1'b0;
    bus.WAYPOINT_SEQUENCER_WR_ADDR      = '0;
    bus.WAYPOINT_SEQUENCER_WR_X_InBus   = '0;
    bus.WAYPOINT_SEQUENCER_WR_Y_InBus   = '0;
    bus.WAYPOINT_SEQUENCER_WR_Z_InBus   = '0;
    bus.WAYPOINT_SEQUENCER_LAST_ADDR    = '0;
    bus.WAYPOINT_SEQUENCER_START        = 1'b0;
    bus.WAYPOINT_SEQUENCER_ABORT        = 1'b0;
    bus.WAYPOINT_SEQUENCER_POSE_VALID   = 1'b0;
    bus.WAYPOINT_SEQUENCER_POSE_X_InBus = '0;
    bus.WAYPOINT_SEQUENCER_POSE_Y_InBus = '0;
    bus.WAYPOINT_SEQUENCER_POSE_Z_InBus = '0;
    bus.WAYPOINT_SEQUENCER_GOAL_FLAG    = 1'b1;
    #1 rst = 1'b1;
    #1 chk_idle_outputs("reset");
    tick();
    tick();
    rst = 1'b0;

    // Table: wp0 = (+3, +10, -200), wp1 = (+1, -1, -0)
    wr(3'd0, P3, P10, N200);
    wr(3'd1, P1, N1, NZ);

    // Single waypoint: -0 pose, subtraction cases, saturation, then settle to DONE
    expect_stop(3'd0, 1'b1, 1'b0, -1);
    run(3'd0);
    pose(NZ, P0, P0, 1'b1, P3, P10, N200, 3'd0, 1'b0);
    pose(P5, P0, P100, 1'b1, N2, P10, NSAT, 3'd0, 1'b0);
    repeat (4) pose(P3, P10, N200, 1'b0, P0, P0, P0, 3'd0, 1'b0);
    tick();

    // Settle reset by a high flag, then advance to wp1
    expect_stop(3'd1, 1'b1, 1'b0, -1);
    run(3'd1);
    for (int i = 0; i < 7; i++) pose(P3, P10, N200, fl[i], P0, P0, P0, 3'd0, 1'b0);
    tick();
    repeat (4) pose(P2, N1, NZ, 1'b0, N1, P0, P0, 3'd1, 1'b0);
    tick();

    // ABORT on the 4th settle sample suppresses DONE
    expect_stop(3'd0, 1'b0, 1'b0, -1);
    run(3'd0);
    repeat (3) pose(P3, P10, N200, 1'b0, P0, P0, P0, 3'd0, 1'b0);
    pose(P3, P10, N200, 1'b0, P0, P0, P0, 3'd0, 1'b1);
    tick();
    wr(3'd0, P1_5, P0, P90);

    // Timeout with flag held high: busy for exactly 100 cycles
    expect_stop(3'd0, 1'b0, 1'b1, 100);
    run(3'd0);
    pose(P0, P0, P0, 1'b1, P1_5, P0, P90, 3'd0, 1'b0);
    repeat (110) tick();
    chk("timeout_sticky", 32'(bus.WAYPOINT_SEQUENCER_TIMEOUT), 32'd1);

    // Async reset mid-TRACK
    run(3'd1);
    pose(P0, P0, P0, 1'b1, P1_5, P0, P90, 3'd0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("async_reset");
    tick();
    rst = 1'b0;
    tick();

    // Rerun the retained table
    expect_stop(3'd1, 1'b1, 1'b0, -1);
    run(3'd1);
    pose(P0, P0, P0, 1'b1, P1_5, P0, P90, 3'd0, 1'b0);
    repeat (4) pose(P1_5, P0, P90, 1'b0, P0, P0, P0, 3'd0, 1'b0);
    tick();
    repeat (4) pose(P0, P0, P0, 1'b0, P1, N1, P0, 3'd1, 1'b0);
    repeat (3) tick();

    chk("start_queue_left", 32'(q_start.size()), 32'd0);
    chk("err_queue_left", 32'(q_err.size()), 32'd0);
    chk("stop_queue_left", 32'(q_stop.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/waypoint_sequencer.md
# waypoint_sequencer

Sequences the robot through a stored list of target poses (X, Y, θ). It computes sign-magnitude position and heading errors from each pose update and drives them into the downstream error-to-velocity controller. The controller's active-low goal flag tells it when a waypoint is reached; after a programmable settle count it advances to the next waypoint. It sits between odometry/pose estimation and the error controller, and is the only driver of that controller's error inputs.

## Interface
- N_WIDTH, 17: data word width; sign-magnitude format, 1 sign + 8 integer + 8 fraction bits (cm or deg).
- ADDR_W, 3: waypoint table address width; table depth 2^ADDR_W.
- SETTLE_COUNT, 4: consecutive pose samples with goal flag low required before advancing; legal range 1..15.
- TIMEOUT_CYCLES, 32'd500_000_000: clock cycles allowed per waypoint (10 s at 50 MHz).

Ports:
- WAYPOINT_SEQUENCER_CLOCK_50  in  1  system clock; the only clock.
- WAYPOINT_SEQUENCER_RESET_InHigh  in  1  asynchronous, active-high reset.
- WAYPOINT_SEQUENCER_WR_EN  in  1  table write strobe.
- WAYPOINT_SEQUENCER_WR_ADDR  in  ADDR_W  table write address.
- WAYPOINT_SEQUENCER_WR_X/WR_Y/WR_Z_InBus  in  N_WIDTH each  waypoint goal X, Y, θ.
- WAYPOINT_SEQUENCER_LAST_ADDR  in  ADDR_W  index of final waypoint; sampled on START.
- WAYPOINT_SEQUENCER_START  in  1  run request, single-cycle pulse.
- WAYPOINT_SEQUENCER_ABORT  in  1  stop request.
- WAYPOINT_SEQUENCER_POSE_VALID  in  1  pose sample strobe.
- WAYPOINT_SEQUENCER_POSE_X/POSE_Y/POSE_Z_InBus  in  N_WIDTH each  current pose.
- WAYPOINT_SEQUENCER_GOAL_FLAG  in  1  from error controller; low = waypoint reached.
- WAYPOINT_SEQUENCER_ERR_X/ERR_Y/ERR_Z_OutBus  out  N_WIDTH each  registered errors to error controller.
- WAYPOINT_SEQUENCER_BUSY  out  1  high while running.
- WAYPOINT_SEQUENCER_DONE  out  1  one-cycle pulse when the last waypoint settles.
- WAYPOINT_SEQUENCER_TIMEOUT  out  1  sticky; cleared by the next accepted START.
- WAYPOINT_SEQUENCER_WP_INDEX  out  ADDR_W  current waypoint index.

## Operation
- Table: 2^ADDR_W entries of {X, Y, Z}. Not cleared by reset. Writes are accepted only in IDLE and ignored while BUSY.
- States:
  - IDLE: START loads LAST_ADDR, clears index, settle counter and timeout counter, clears TIMEOUT, then → FETCH.
  - FETCH (1 cycle): latch table[index] into goal registers, → TRACK.
  - TRACK: on POSE_VALID, register err = goal − pose for all three axes, → CHECK.
  - CHECK (1 cycle): sample GOAL_FLAG, which reflects the registered errors.
    - Flag low: settle_cnt+1. If it reaches SETTLE_COUNT → ADVANCE, else → TRACK.
    - Flag high: settle_cnt = 0, → TRACK.
  - ADVANCE: if index == LAST_ADDR, pulse DONE and → IDLE. Otherwise index+1, settle_cnt = 0, timeout counter = 0, → FETCH.
- Timeout counter runs in FETCH/TRACK/CHECK. When it reaches TIMEOUT_CYCLES: set TIMEOUT, → IDLE.
- On any entry to IDLE (done, abort, timeout, reset), ERR_* are set to +0 so the controller commands zero velocity. WP_INDEX holds its last value.
- Subtraction (sign-magnitude):
  - Same signs: add magnitudes.
  - Differing signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
  - Magnitude overflow saturates to 16'hFFFF.
  - A zero result is always +0 (sign 0).
- Input −0 is treated as +0.

## Timing
- Reset values: ERR_* = 0, BUSY = 0, DONE = 0, TIMEOUT = 0, WP_INDEX = 0, state IDLE, counters 0.
- START accepted in IDLE → BUSY high next cycle → goal latched after FETCH.
- POSE_VALID in TRACK → ERR_* updated next edge → GOAL_FLAG sampled one cycle later (CHECK). Error-to-decision latency is 2 cycles.
- POSE_VALID in FETCH/CHECK/ADVANCE is dropped, with no buffering. Pose sources must space strobes at least 3 cycles apart.
- ABORT has priority over everything, including START in the same cycle and a DONE or timeout decision. Next state is IDLE, ERR_* = 0, BUSY = 0, no DONE pulse.
- START while BUSY is ignored.
- LAST_ADDR = 0 runs a single waypoint.
- Asynchronous reset mid-run forces IDLE and zeroes outputs immediately. Table contents are retained.

## Structure
- Shared package constants: sign-magnitude width and field positions, +0 constant, saturation magnitude, state encoding (IDLE, FETCH, TRACK, CHECK, ADVANCE).
- One sub-module: sm_subtract (combinational sign-magnitude subtract with saturation), instantiated three times.

## Test plan
- Single waypoint, Y goal 0_00001010_00000000 (10 cm), pose 0: ERR_Y = 0_00001010_00000000. After pose Y reaches 10 and GOAL_FLAG is held low for 4 strobes, DONE pulses once and ERR_* = 0.
- Subtraction: goal X = +3, pose X = +5 → ERR_X = 1_00000010_00000000. Goal Z = −200, pose Z = +100 → ERR_Z = 1_11111111_11111111 (saturated). Goal = pose → +0.
- Settle reset: flag low, low, high, low×4 → advance only after the final 4th low. WP_INDEX goes 0→1 with LAST_ADDR = 1.
- ABORT asserted in the same cycle as the 4th settle sample → no DONE, BUSY = 0, ERR_* = 0. A subsequent WR_EN is accepted.
- TIMEOUT_CYCLES = 100 with GOAL_FLAG held high → TIMEOUT = 1 at cycle 100, → IDLE. The next START clears TIMEOUT.
- Asynchronous reset mid-TRACK → all outputs at reset values without waiting for a clock edge. Restarting runs the previously written table unchanged.
